simd_func_unit: RTL and testbench

- Parametrised multi-lane successor to the single-thread functional unit. LANES threads execute one common instruction in lockstep, each against a private register file.
- Per-lane active mask supports divergence.
- Valid/ready issue handshake, registered result with valid strobe.
- UDIV is a multi-cycle iterative divider instead of a combinational one.
- Sits between the warp scheduler (issue side) and the writeback/result collector.

---
 rtl/simd_func_unit.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_simd_func_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_func_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : simd_func_unit                                           |
// | Description : Multi-lane SIMD functional unit. LANES threads run one   |
// |               common instruction in lockstep. Each lane has a private  |
// |               register file and a per-lane active mask. ADD/SUB/MUL/   |
// |               FADD/FSUB/LOAD complete in one cycle. UDIV is a          |
// |               restoring divider that takes WIDTH+1 cycles.             |
// | Ports       : clk, rst_n (async, active-low)                           |
// |               issue_valid/issue_ready  issue handshake                 |
// |               op, src1, src2, dest, lane_mask, ld_data  instruction    |
// |               result_valid, result_data  registered per-lane results   |
// |               thread_complete  set by RET, cleared by LOAD             |
// |               op_error  FADD/FSUB strobe when WIDTH != 32              |
// | Option      : SIMD_FU_DIVZERO_FLAG_EN adds divzero_flag[LANES-1:0],    |
// |               a sticky per-lane divide-by-zero flag                    |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module simd_func_unit #(
    parameter  int LANES    = 4,
    parameter  int NUM_REGS = 32,
    parameter  int WIDTH    = 32,
    localparam int REG_AW   = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  logic [2:0]               op,
    input  logic [REG_AW-1:0]        src1,
    input  logic [REG_AW-1:0]        src2,
    input  logic [REG_AW-1:0]        dest,
    input  logic [LANES-1:0]         lane_mask,
    input  logic [LANES*WIDTH-1:0]   ld_data,
    output logic                     result_valid,
    output logic [LANES*WIDTH-1:0]   result_data,
    output logic                     thread_complete,
    output logic                     op_error
`ifdef SIMD_FU_DIVZERO_FLAG_EN
    ,
    output logic [LANES-1:0]         divzero_flag
`endif
);

    localparam logic [2:0] c_OP_ADD  = 3'b000;
    localparam logic [2:0] c_OP_SUB  = 3'b001;
    localparam logic [2:0] c_OP_MUL  = 3'b010;
    localparam logic [2:0] c_OP_UDIV = 3'b011;
    localparam logic [2:0] c_OP_FADD = 3'b100;
    localparam logic [2:0] c_OP_FSUB = 3'b101;
    localparam logic [2:0] c_OP_LOAD = 3'b110;
    localparam logic [2:0] c_OP_RET  = 3'b111;

    localparam bit             c_FP_OK = (WIDTH == 32);
    localparam int             c_CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_DIV  = 1'b1
    } state_t;

    // IEEE-754 single-precision add, round-to-nearest-even. Subnormals are
    // handled by treating exponent 0 as 1 with no hidden bit.
    function automatic logic [31:0] fl32(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] big, sml;
        logic [7:0]  eb, es, d;
        logic [23:0] mb, ms;
        logic [26:0] xb, xs;     // mantissa plus guard/round/sticky
        logic [27:0] sum;
        logic [9:0]  e;
        logic [24:0] rm;
        logic        rnd;
        if ((x[30:23] == 8'hFF && x[22:0] != 23'd0) ||
            (y[30:23] == 8'hFF && y[22:0] != 23'd0))
            return 32'h7FC0_0000;
        if (x[30:23] == 8'hFF && y[30:23] == 8'hFF)
            return (x[31] != y[31]) ? 32'h7FC0_0000 : x;
        if (x[30:23] == 8'hFF) return x;
        if (y[30:23] == 8'hFF) return y;
        if (x[30:0] >= y[30:0]) begin big = x; sml = y; end
        else                    begin big = y; sml = x; end
        eb = big[30:23];
        es = sml[30:23];
        mb = {|eb, big[22:0]};
        ms = {|es, sml[22:0]};
        if (eb == 8'd0) eb = 8'd1;
        if (es == 8'd0) es = 8'd1;
        d  = eb - es;
        xb = {mb, 3'b000};
        xs = {ms, 3'b000};
        if (d >= 8'd27) begin
            xs = {26'd0, |ms};
        end else begin
            for (int i = 0; i < 27; i++)
                if (i < int'(d)) xs = {1'b0, xs[26:2], xs[1] | xs[0]};
        end
        if (big[31] == sml[31]) sum = {1'b0, xb} + {1'b0, xs};
        else                    sum = {1'b0, xb} - {1'b0, xs};
        // Exact cancellation gives +0 unless both operands were -0.
        if (sum == 28'd0) return {big[31] & sml[31], 31'd0};
        e = {2'b00, eb};
        if (sum[27]) begin
            sum = {1'b0, sum[27:2], sum[1] | sum[0]};
            e   = e + 10'd1;
        end else begin
            for (int i = 0; i < 26; i++)
                if (!sum[26] && e > 10'd1) begin
                    sum = sum << 1;
                    e   = e - 10'd1;
                end
        end
        rnd = sum[2] & (sum[1] | sum[0] | sum[3]);
        rm  = {1'b0, sum[26:3]} + {24'd0, rnd};
        if (rm[24]) begin
            rm = {1'b0, rm[24:1]};
            e  = e + 10'd1;
        end
        if (e >= 10'd255) return {big[31], 8'hFF, 23'd0};
        // A result without the hidden bit is subnormal: exponent field 0.
        return {big[31], rm[23] ? e[7:0] : 8'd0, rm[22:0]};
    endfunction

    state_t                r_state;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [WIDTH-1:0]      r_regs [LANES][NUM_REGS];
    logic [WIDTH-1:0]      r_quo  [LANES];
    logic [WIDTH-1:0]      r_rem  [LANES];
    logic [WIDTH-1:0]      r_dvs  [LANES];
    logic [LANES-1:0]      r_div_mask;
    logic [REG_AW-1:0]     r_div_dest;
    logic                  r_result_valid;
    logic [LANES*WIDTH-1:0] r_result_data;
    logic                  r_thread_complete;
    logic                  r_op_error;

    logic [WIDTH-1:0]      w_a        [LANES];
    logic [WIDTH-1:0]      w_b        [LANES];
    logic [WIDTH-1:0]      w_fp       [LANES];
    logic [WIDTH-1:0]      w_single   [LANES];
    logic [WIDTH-1:0]      w_quo_nxt  [LANES];
    logic [WIDTH-1:0]      w_rem_nxt  [LANES];
    logic [LANES*WIDTH-1:0] w_single_data;
    logic [LANES*WIDTH-1:0] w_div_data;

    logic w_exec;        // accepted and not swallowed by a completed thread
    logic w_is_fp;
    logic w_wb_single;   // single-cycle op writes back this edge
    logic w_start_div;
    logic w_wb_div;      // last division cycle: write quotients back

    assign issue_ready = (r_state == ST_IDLE);
    assign w_exec      = issue_valid && issue_ready && (!r_thread_complete || op == c_OP_LOAD);
    assign w_is_fp     = (op == c_OP_FADD) || (op == c_OP_FSUB);
    assign w_start_div = w_exec && (op == c_OP_UDIV);
    assign w_wb_single = w_exec && (op != c_OP_UDIV) && (op != c_OP_RET) && !(w_is_fp && !c_FP_OK);
    assign w_wb_div    = (r_state == ST_DIV) && (r_cnt == '0);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_a[l] = r_regs[l][src1];
        assign w_b[l] = r_regs[l][src2];

        if (WIDTH == 32) begin : g_fp32
            assign w_fp[l] = fl32(w_a[l], (op == c_OP_FSUB) ? {~w_b[l][31], w_b[l][30:0]} : w_b[l]);
        end else begin : g_no_fp
            assign w_fp[l] = '0;
        end

        always_comb begin
            case (op)
                c_OP_ADD:  w_single[l] = w_a[l] + w_b[l];
                c_OP_SUB:  w_single[l] = w_a[l] + ~w_b[l] + c_ONE;
                c_OP_MUL:  w_single[l] = w_a[l] * w_b[l];
                c_OP_LOAD: w_single[l] = ld_data[l*WIDTH +: WIDTH];
                default:   w_single[l] = w_fp[l];
            endcase
        end

        // One restoring-division step: shift the next dividend bit into the
        // partial remainder and subtract the divisor when it fits. A zero
        // divisor always fits, which yields an all-ones quotient.
        logic [WIDTH:0] w_shift;
        logic [WIDTH:0] w_diff;
        assign w_shift = {r_rem[l], r_quo[l][WIDTH-1]};
        assign w_diff  = w_shift - {1'b0, r_dvs[l]};
        always_comb begin
            if (w_shift >= {1'b0, r_dvs[l]}) begin
                w_rem_nxt[l] = w_diff[WIDTH-1:0];
                w_quo_nxt[l] = {r_quo[l][WIDTH-2:0], 1'b1};
            end else begin
                w_rem_nxt[l] = w_shift[WIDTH-1:0];
                w_quo_nxt[l] = {r_quo[l][WIDTH-2:0], 1'b0};
            end
        end

        assign w_single_data[l*WIDTH +: WIDTH] = lane_mask[l]  ? w_single[l] : '0;
        assign w_div_data[l*WIDTH +: WIDTH]    = r_div_mask[l] ? r_quo[l]    : '0;
    end

    // Register files: one write port per lane, shared by single-cycle ops
    // and the division writeback (never active in the same cycle).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < LANES; l++)
                for (int r = 0; r < NUM_REGS; r++)
                    r_regs[l][r] <= '0;
        end else begin
            for (int l = 0; l < LANES; l++) begin
                if (w_wb_single && lane_mask[l])
                    r_regs[l][dest] <= w_single[l];
                else if (w_wb_div && r_div_mask[l])
                    r_regs[l][r_div_dest] <= r_quo[l];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= ST_IDLE;
            r_cnt             <= '0;
            r_div_mask        <= '0;
            r_div_dest        <= '0;
            r_result_valid    <= 1'b0;
            r_result_data     <= '0;
            r_thread_complete <= 1'b1;
            r_op_error        <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                r_quo[l] <= '0;
                r_rem[l] <= '0;
                r_dvs[l] <= '0;
            end
        end else begin
            r_result_valid <= 1'b0;
            r_op_error     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_exec) begin
                        if (op == c_OP_RET) begin
                            r_thread_complete <= 1'b1;
                        end else if (op == c_OP_UDIV) begin
                            r_state    <= ST_DIV;
                            r_cnt      <= c_CNT_W'(WIDTH);
                            r_div_mask <= lane_mask;
                            r_div_dest <= dest;
                            for (int l = 0; l < LANES; l++) begin
                                r_quo[l] <= w_a[l];
                                r_rem[l] <= '0;
                                r_dvs[l] <= w_b[l];
                            end
                        end else if (w_is_fp && !c_FP_OK) begin
                            r_op_error <= 1'b1;
                        end else begin
                            r_result_valid <= 1'b1;
                            r_result_data  <= w_single_data;
                            if (op == c_OP_LOAD)
                                r_thread_complete <= 1'b0;
                        end
                    end
                end
                ST_DIV: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                        for (int l = 0; l < LANES; l++) begin
                            r_quo[l] <= w_quo_nxt[l];
                            r_rem[l] <= w_rem_nxt[l];
                        end
                    end else begin
                        r_result_valid <= 1'b1;
                        r_result_data  <= w_div_data;
                        r_state        <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef SIMD_FU_DIVZERO_FLAG_EN
    logic [LANES-1:0] r_div_zero;
    logic [LANES-1:0] r_divzero;
    logic [LANES-1:0] w_b_zero;

    for (genvar l = 0; l < LANES; l++) begin : g_bzero
        assign w_b_zero[l] = (w_b[l] == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_zero <= '0;
            r_divzero  <= '0;
        end else begin
            if (w_start_div)
                r_div_zero <= w_b_zero;
            if (w_wb_div)
                r_divzero <= r_divzero | (r_div_mask & r_div_zero);
            else if (w_wb_single && op == c_OP_LOAD)
                r_divzero <= r_divzero & ~lane_mask;
        end
    end

    assign divzero_flag = r_divzero;
`endif

    assign result_valid    = r_result_valid;
    assign result_data     = r_result_data;
    assign thread_complete = r_thread_complete;
    assign op_error        = r_op_error;

endmodule
`default_nettype wire

// File: tb/tb_simd_func_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_simd_func_unit                                        |
// | Description : Scoreboard bench for simd_func_unit (4 lanes x 32 bit).  |
// |               Stimulus pushes hand-computed results; a monitor pops    |
// |               and compares on every result_valid strobe.              |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module tb_simd_func_unit;

    localparam logic [2:0] c_ADD  = 3'b000;
    localparam logic [2:0] c_SUB  = 3'b001;
    localparam logic [2:0] c_MUL  = 3'b010;
    localparam logic [2:0] c_UDIV = 3'b011;
    localparam logic [2:0] c_FADD = 3'b100;
    localparam logic [2:0] c_FSUB = 3'b101;
    localparam logic [2:0] c_LOAD = 3'b110;
    localparam logic [2:0] c_RET  = 3'b111;
    localparam int         c_W    = 32;

    logic         clk;
    logic         rst_n;
    logic         issue_valid;
    logic         issue_ready;
    logic [2:0]   op;
    logic [4:0]   src1, src2, dest;
    logic [3:0]   lane_mask;
    logic [127:0] ld_data;
    logic         result_valid;
    logic [127:0] result_data;
    logic         thread_complete;
    logic         op_error;
`ifdef SIMD_FU_DIVZERO_FLAG_EN
    logic [3:0]   divzero_flag;
`endif

    typedef struct {
        string        name;
        logic [127:0] data;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    simd_func_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .issue_valid     (issue_valid),
        .issue_ready     (issue_ready),
        .op              (op),
        .src1            (src1),
        .src2            (src2),
        .dest            (dest),
        .lane_mask       (lane_mask),
        .ld_data         (ld_data),
        .result_valid    (result_valid),
        .result_data     (result_data),
        .thread_complete (thread_complete),
        .op_error        (op_error)
`ifdef SIMD_FU_DIVZERO_FLAG_EN
        ,.divzero_flag   (divzero_flag)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] pk(input logic [31:0] l3, input logic [31:0] l2,
                                        input logic [31:0] l1, input logic [31:0] l0);
        return {l3, l2, l1, l0};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one instruction for one accept edge. The unit must be ready.
    task automatic issue(input string name, input logic [2:0] o, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [4:0] d, input logic [3:0] m,
                         input logic [127:0] ld);
        @(negedge clk);
        chk({name, "_ready"}, {127'd0, issue_ready}, 128'd1);
        issue_valid = 1'b1;
        op          = o;
        src1        = s1;
        src2        = s2;
        dest        = d;
        lane_mask   = m;
        ld_data     = ld;
        @(posedge clk);
    endtask

    task automatic expect_res(input string name, input logic [127:0] data);
        exp_t e;
        e.name = name;
        e.data = data;
        q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        issue_valid = 1'b0;
    endtask

    // Monitor: every result strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && result_valid) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: got %h expected no result", result_data);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk(e.name, result_data, e.data);
            end
        end
        if (rst_n && op_error) begin
            n_cmp++;
            n_bad++;
            $display("FAIL op_error: got 1 expected 0");
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int lat, low;
        rst_n = 1'b0; issue_valid = 1'b0; op = '0; src1 = '0; src2 = '0;
        dest = '0; lane_mask = '0; ld_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_result_valid", {127'd0, result_valid}, 128'd0);
        chk("rst_result_data", result_data, 128'd0);
        chk("rst_thread_complete", {127'd0, thread_complete}, 128'd1);
        chk("rst_issue_ready", {127'd0, issue_ready}, 128'd1);
        rst_n = 1'b1;

        // Loads and back-to-back dependent integer ops.
        expect_res("load_r1", pk(4, 3, 2, 1));
        issue("load_r1", c_LOAD, 0, 0, 1, 4'hF, pk(4, 3, 2, 1));
        expect_res("load_r2", pk(10, 10, 10, 10));
        issue("load_r2", c_LOAD, 0, 0, 2, 4'hF, pk(10, 10, 10, 10));
        chk("tc_after_load", {127'd0, thread_complete}, 128'd0);
        expect_res("add_r3", pk(14, 13, 12, 11));
        issue("add_r3", c_ADD, 1, 2, 3, 4'hF, '0);
        expect_res("sub_r4", pk(32'hFFFF_FFFA, 32'hFFFF_FFF9, 32'hFFFF_FFF8, 32'hFFFF_FFF7));
        issue("sub_r4", c_SUB, 1, 2, 4, 4'hF, '0);
        expect_res("mul_r7", pk(56, 39, 24, 11));
        issue("mul_r7", c_MUL, 3, 1, 7, 4'hF, '0);
        expect_res("add_self_r3", pk(28, 26, 24, 22));
        issue("add_self_r3", c_ADD, 3, 3, 3, 4'hF, '0);
        expect_res("readback_r3", pk(28, 26, 24, 22));
        issue("readback_r3", c_ADD, 3, 0, 10, 4'hF, '0);
        expect_res("load_r11", {4{32'hFFFF_FFFF}});
        issue("load_r11", c_LOAD, 0, 0, 11, 4'hF, {4{32'hFFFF_FFFF}});
        expect_res("add_wrap", pk(3, 2, 1, 0));
        issue("add_wrap", c_ADD, 11, 1, 12, 4'hF, '0);
        expect_res("mul_wrap", pk(1, 1, 1, 1));
        issue("mul_wrap", c_MUL, 11, 11, 12, 4'hF, '0);

        // UDIV with a zero divisor in lane 2; inputs wiggled while busy.
        expect_res("load_r6", pk(4, 0, 3, 1));
        issue("load_r6", c_LOAD, 0, 0, 6, 4'hF, pk(4, 0, 3, 1));
        expect_res("udiv_r5", pk(2, 32'hFFFF_FFFF, 3, 10));
        issue("udiv_r5", c_UDIV, 2, 6, 5, 4'hF, '0);
        #1;
        lat = 0;
        low = issue_ready ? 0 : 1;
        op = c_ADD; dest = 5'd5; lane_mask = 4'h0; src1 = 5'd0; src2 = 5'd0;
        for (int k = 1; k <= 60 && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (result_valid) begin
                lat = k;
                issue_valid = 1'b0;
            end else if (!issue_ready) begin
                low++;
            end
        end
        if (lat == 0) issue_valid = 1'b0;
        // Busy from the accept edge until the result edge.
        chk("udiv_latency", 128'(lat), 128'(c_W + 1));
        chk("udiv_busy_cycles", 128'(low), 128'(c_W + 1));
`ifdef SIMD_FU_DIVZERO_FLAG_EN
        chk("divzero_set", {124'd0, divzero_flag}, 128'h4);
`endif
        expect_res("readback_r5", pk(2, 32'hFFFF_FFFF, 3, 10));
        issue("readback_r5", c_ADD, 5, 0, 13, 4'hF, '0);

        // Floating point.
        expect_res("load_r14", {4{32'h3F80_0000}});
        issue("load_r14", c_LOAD, 0, 0, 14, 4'hF, {4{32'h3F80_0000}});
        expect_res("load_r15", {4{32'h4000_0000}});
        issue("load_r15", c_LOAD, 0, 0, 15, 4'hF, {4{32'h4000_0000}});
        expect_res("fadd", {4{32'h4040_0000}});
        issue("fadd", c_FADD, 14, 15, 16, 4'hF, '0);
        expect_res("fsub", {4{32'hBF80_0000}});
        issue("fsub", c_FSUB, 14, 15, 17, 4'hF, '0);
        expect_res("fsub_zero", 128'd0);
        issue("fsub_zero", c_FSUB, 14, 14, 17, 4'hF, '0);

        // Masked lanes.
        expect_res("mask_add", pk(0, 20, 0, 20));
        issue("mask_add", c_ADD, 2, 2, 1, 4'b0101, '0);
        expect_res("mask_keep", pk(4, 20, 2, 20));
        issue("mask_keep", c_ADD, 1, 0, 18, 4'hF, '0);
        expect_res("mask_none", 128'd0);
        issue("mask_none", c_ADD, 2, 2, 1, 4'b0000, '0);
`ifdef SIMD_FU_DIVZERO_FLAG_EN
        expect_res("load_clr", pk(0, 9, 0, 0));
        issue("load_clr", c_LOAD, 0, 0, 23, 4'b0100, pk(9, 9, 9, 9));
        idle();
        chk("divzero_clr", {124'd0, divzero_flag}, 128'h0);
`endif

        // RET, swallowed ADD, then LOAD reopens the thread.
        issue("ret", c_RET, 0, 0, 0, 4'hF, '0);
        idle();
        chk("tc_after_ret", {127'd0, thread_complete}, 128'd1);
        issue("add_dead", c_ADD, 2, 2, 19, 4'hF, '0);
        idle();
        chk("tc_after_dead", {127'd0, thread_complete}, 128'd1);
        expect_res("load_r20", {4{32'd7}});
        issue("load_r20", c_LOAD, 0, 0, 20, 4'hF, {4{32'd7}});
        expect_res("r19_untouched", 128'd0);
        issue("r19_untouched", c_ADD, 19, 0, 21, 4'hF, '0);
        idle();
        chk("tc_after_reload", {127'd0, thread_complete}, 128'd0);

        // Reset in the middle of a division.
        repeat (2) @(negedge clk);
        issue("udiv_abort", c_UDIV, 2, 1, 22, 4'hF, '0);
        idle();
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_result_valid", {127'd0, result_valid}, 128'd0);
        chk("abort_result_data", result_data, 128'd0);
        chk("abort_issue_ready", {127'd0, issue_ready}, 128'd1);
        chk("abort_tc", {127'd0, thread_complete}, 128'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        expect_res("regs_cleared", 128'd0);
        issue("regs_cleared", c_LOAD, 0, 0, 24, 4'h0, {4{32'd5}});
        expect_res("r2_cleared", 128'd0);
        issue("r2_cleared", c_ADD, 2, 1, 25, 4'hF, '0);
        idle();
        repeat (4) @(negedge clk);
        chk("sb_drain", 128'(q.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
